rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter sharing one resource among eight requesters. A rotating 8-to-3 priority encoder picks the next owner. The arbiter holds the grant while the owner keeps its request asserted, forces rotation after a bounded hold time, and inserts one idle turnaround cycle between owners. It sits in front of any shared datapath whose select is driven by `gnt_code`.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive grant cycles per ownership; 0 disables the limit.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req` in 8: request vector; bit i = requester i.
- `gnt` out 8: one-hot grant; all-zero when no owner.
- `gnt_code` out 3: binary index of the owner; 0 when `gnt_valid`=0.
- `gnt_valid` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse on the edge where a forced release happens.

## Operation
- States: IDLE, GRANT, GAP.
- IDLE:
  - If `req`≠0: search ascending from `(last+1) mod 8` with wrap-around. The first set bit becomes owner, `last`←owner, and the state moves to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `gnt`=1<<owner, `gnt_code`=owner, `gnt_valid`=1, and the hold counter increments each cycle.
  - Release when `req[owner]`=0 (voluntary), or when `MAX_HOLD`≠0 and the counter reaches `MAX_HOLD` with `req[owner]` still 1 (forced, `timeout`=1 for that cycle).
  - Either release moves to GAP.
  - Requests from non-owners never preempt the owner.
- GAP: all grant outputs are 0 for exactly one cycle, then the state goes to IDLE unconditionally.
- Pointer `last`: updates only on a new grant. Reset value is 7, so the first search starts at bit 0.
- Forced release does not block the old owner. If it is the only requester, it is re-granted after GAP. Otherwise rotation from `last` serves others first.
- Hold counter: width `$clog2(MAX_HOLD+1)`, minimum 1 bit. It clears on entry to GRANT and saturates rather than wrapping when `MAX_HOLD`=0.
- Request deasserted by a non-owner: no effect. Request raised during GAP: sampled in the following IDLE cycle.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `gnt_code`=0, `gnt_valid`=0, `timeout`=0, state=IDLE, `last`=7, counter=0.
- Reset asserted mid-grant: outputs are 0 at the next edge and the pointer returns to 7.
- Request-to-grant latency: a request sampled at IDLE edge N drives `gnt_valid`=1 from edge N+1.
- A single owner holds the grant for min(request duration, `MAX_HOLD`) cycles.
- Voluntary release: `req[owner]` falls before edge N, so `gnt`=0 from edge N (GAP). The earliest next grant is edge N+2.
- Forced release: `timeout` and `gnt`=0 both appear at the same edge, and the grant lasted exactly `MAX_HOLD` cycles.
- Simultaneous requests in IDLE: exactly one is granted, chosen by rotation order. `gnt` is never multi-hot.
- Back-to-back ownership period is therefore hold + 2 cycles (GRANT…, GAP, IDLE).

## Structure
- Package `arb_pkg` holds:
  - `N_REQ`=8 and `CODE_W`=3.
  - State enum `arb_state_t` {IDLE, GRANT, GAP}.
  - Function `onehot_of(code)`.
- Sub-module `rr_prio_enc8` is combinational and has the following ports:
  - inputs: `data[7:0]` and start index `base[2:0]`;
  - outputs: `code[2:0]` and `any`.
- `rr_prio_enc8` implements the wrap-around first-set search. The top level instantiates it once with `base`=`last`+1.
- Top level contains the FSM, hold counter, pointer and output registers.

## Test plan
- Reset then single request:
  - Reset then `req`=8'b00000100: `gnt_valid`=1, `gnt_code`=2, `gnt`=8'b00000100 one cycle after sampling.
  - Dropping `req` gives one GAP cycle with all outputs 0.
- Rotation with `req`=8'hFF held and `MAX_HOLD`=4:
  - Grants go 0,1,2,…,7,0 in order, each lasting 4 cycles with `timeout` pulsing at every release.
  - Owner changes are separated by 2 non-grant cycles.
- Wrap-around: after owner 6 releases, `req`=8'b01000001 grants 0, not 6. Then `req`=8'b01000000 grants 6.
- Sole requester under a forced limit: `req`=8'b10000000 held with `MAX_HOLD`=3 gives a grant of 3 cycles, `timeout`, GAP, IDLE, then re-grant of 7. This repeats, and `gnt_code`=7 each time.
- `MAX_HOLD`=0: `req`=8'b00000011 held for 40 cycles keeps owner 0 for all 40 cycles with no `timeout`. Releasing `req[0]` grants 1.
- Reset mid-grant: asserting `rst` while owner 5 holds gives all outputs 0 at the next edge. After reset, `req`=8'hFF grants 0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the eight-way round-robin arbiter
//
// Purpose: common constants, FSM state type and a code-to-one-hot helper used
//          by rr_prio_enc8 and rr_arbiter8.
// Ports:   none (package).

package arb_pkg;

   localparam int N_REQ  = 8;
   localparam int CODE_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

   // Expand a binary requester index into its one-hot grant vector.
   function automatic logic [N_REQ-1:0] onehot_of(input logic [CODE_W-1:0] code);
      logic [N_REQ-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_prio_enc8.sv
// rtl/rr_prio_enc8.sv - rotating 8-to-3 first-set priority encoder
//
// Purpose: finds the first set bit of data searching upward from bit base,
//          wrapping from bit 7 back to bit 0. Purely combinational.
// Ports:
//   data [7:0] in  : candidate vector
//   base [2:0] in  : index where the search starts
//   code [2:0] out : index of the first set bit found (0 when none)
//   any        out : at least one bit of data is set

module rr_prio_enc8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0]  data,
   input  logic [CODE_W-1:0] base,
   output logic [CODE_W-1:0] code,
   output logic              any
);

   logic [N_REQ-1:0]  w_rot;
   logic [CODE_W-1:0] w_off;

   always_comb begin
      w_rot = '0;
      w_off = '0;
      // Rotate so that bit base lands at position 0; the 3-bit index sum wraps
      // naturally modulo 8.
      for (int i = 0; i < N_REQ; i++) begin
         w_rot[i] = data[base + CODE_W'(i)];
      end
      // Scanning downward lets the lowest set offset win.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = CODE_W'(i);
         end
      end
      any  = |data;
      code = any ? (base + w_off) : '0;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with hold limit and turnaround gap
//
// Purpose: grants one of eight requesters at a time, keeps the grant while the
//          owner requests, forces release after MAX_HOLD cycles (0 = no limit)
//          and inserts one idle GAP cycle between owners. All outputs registered.
// Ports:
//   clk            in  : clock, rising edge
//   rst            in  : synchronous reset, active high
//   req [7:0]      in  : request vector, bit i = requester i
//   gnt [7:0]      out : one-hot grant, zero when no owner
//   gnt_code [2:0] out : binary owner index, zero when gnt_valid = 0
//   gnt_valid      out : a grant is active
//   timeout        out : one-cycle pulse on the edge of a forced release

module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 15
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic [CODE_W-1:0] gnt_code,
   output logic              gnt_valid,
   output logic              timeout
);

   // A zero limit would give a zero-width counter; keep at least one bit.
   localparam int CNT_W = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

   arb_state_t        r_state;
   logic [CODE_W-1:0] r_last;
   logic [CNT_W-1:0]  r_cnt;
   logic [N_REQ-1:0]  r_gnt;
   logic [CODE_W-1:0] r_gnt_code;
   logic              r_gnt_valid;
   logic              r_timeout;

   logic [CODE_W-1:0] w_base;
   logic [CODE_W-1:0] w_code;
   logic              w_any;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_owner_req;
   logic              w_hit_lim;

   // Search starts just past the previous owner; 7 + 1 wraps to 0 after reset.
   assign w_base = r_last + CODE_W'(1);

   rr_prio_enc8 u_enc (
      .data (req),
      .base (w_base),
      .code (w_code),
      .any  (w_any)
   );

   // r_last always names the current owner while in GRANT, since it is only
   // loaded when a new grant is issued.
   assign w_owner_req = req[r_last];

   // Saturating increment: only reachable with MAX_HOLD = 0, where the count
   // is never compared and must simply not wrap.
   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_W'(1));

   // The counter holds the number of completed grant cycles minus one, so the
   // incremented value equals the length of the grant ending at this edge.
   assign w_hit_lim = (MAX_HOLD != 0) && (w_cnt_inc == HOLD_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last      <= 3'd7;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_gnt_code  <= '0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state     <= GRANT;
                  r_last      <= w_code;
                  r_cnt       <= '0;
                  r_gnt       <= onehot_of(w_code);
                  r_gnt_code  <= w_code;
                  r_gnt_valid <= 1'b1;
               end
            end
            GRANT: begin
               r_cnt <= w_cnt_inc;
               // Other requesters are ignored here; only the owner's own
               // request or the hold limit ends the grant.
               if (!w_owner_req || w_hit_lim) begin
                  r_state     <= GAP;
                  r_gnt       <= '0;
                  r_gnt_code  <= '0;
                  r_gnt_valid <= 1'b0;
                  // Owner still requesting means the limit forced the release.
                  r_timeout   <= w_owner_req;
               end
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state     <= IDLE;
               r_gnt       <= '0;
               r_gnt_code  <= '0;
               r_gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_code  = r_gnt_code;
   assign gnt_valid = r_gnt_valid;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8

module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_x   [3];
   logic [7:0] gnt_x   [3];
   logic [2:0] code_x  [3];
   logic       valid_x [3];
   logic       to_x    [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // unit 0: MAX_HOLD=4, unit 1: MAX_HOLD=3, unit 2: MAX_HOLD=0
   rr_arbiter8 #(.MAX_HOLD(4)) u_a (
      .clk(clk), .rst(rst), .req(req_x[0]), .gnt(gnt_x[0]),
      .gnt_code(code_x[0]), .gnt_valid(valid_x[0]), .timeout(to_x[0]));
   rr_arbiter8 #(.MAX_HOLD(3)) u_b (
      .clk(clk), .rst(rst), .req(req_x[1]), .gnt(gnt_x[1]),
      .gnt_code(code_x[1]), .gnt_valid(valid_x[1]), .timeout(to_x[1]));
   rr_arbiter8 #(.MAX_HOLD(0)) u_c (
      .clk(clk), .rst(rst), .req(req_x[2]), .gnt(gnt_x[2]),
      .gnt_code(code_x[2]), .gnt_valid(valid_x[2]), .timeout(to_x[2]));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_out(input int u, input string tag, input logic [7:0] eg,
                             input logic [2:0] ec, input logic ev, input logic et);
      check_val({tag, ".gnt"},       32'(gnt_x[u]),   32'(eg));
      check_val({tag, ".gnt_code"},  32'(code_x[u]),  32'(ec));
      check_val({tag, ".gnt_valid"}, 32'(valid_x[u]), 32'(ev));
      check_val({tag, ".timeout"},   32'(to_x[u]),    32'(et));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] eg;
      for (int u = 0; u < 3; u++) req_x[u] = 8'h00;

      // reset state
      tick();
      tick();
      expect_out(0, "rst_a", 8'h00, 3'd0, 1'b0, 1'b0);
      expect_out(1, "rst_b", 8'h00, 3'd0, 1'b0, 1'b0);
      expect_out(2, "rst_c", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // single request then voluntary release
      req_x[0] = 8'b0000_0100;
      tick();
      expect_out(0, "single", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
      req_x[0] = 8'h00;
      tick();
      expect_out(0, "single_gap", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      expect_out(0, "single_idle", 8'h00, 3'd0, 1'b0, 1'b0);

      // rotation with all requesting, limit 4
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_x[0] = 8'hFF;
      tick();
      for (int k = 0; k <= 8; k++) begin
         eg = 8'h01 << (k % 8);
         for (int c = 0; c < 4; c++) begin
            expect_out(0, $sformatf("rot_grant%0d_%0d", k, c), eg, 3'(k % 8), 1'b1, 1'b0);
            tick();
         end
         expect_out(0, $sformatf("rot_gap%0d", k), 8'h00, 3'd0, 1'b0, 1'b1);
         if (k == 8) req_x[0] = 8'h00;
         tick();
         expect_out(0, $sformatf("rot_idle%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
         tick();
      end
      expect_out(0, "rot_end", 8'h00, 3'd0, 1'b0, 1'b0);

      // wrap-around past owner 6
      req_x[0] = 8'b0100_0000;
      tick();
      expect_out(0, "wrap_own6", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
      req_x[0] = 8'h00;
      tick();
      expect_out(0, "wrap_gap1", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      req_x[0] = 8'b0100_0001;
      tick();
      expect_out(0, "wrap_own0", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
      tick();
      expect_out(0, "wrap_nopreempt", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
      req_x[0] = 8'b0100_0000;
      tick();
      expect_out(0, "wrap_gap2", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      expect_out(0, "wrap_idle2", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      expect_out(0, "wrap_own6b", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
      req_x[0] = 8'h00;
      tick();
      tick();

      // sole requester 7 under limit 3
      req_x[1] = 8'b1000_0000;
      tick();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            expect_out(1, $sformatf("sole_grant%0d_%0d", r, c), 8'b1000_0000, 3'd7, 1'b1, 1'b0);
            tick();
         end
         expect_out(1, $sformatf("sole_gap%0d", r), 8'h00, 3'd0, 1'b0, 1'b1);
         if (r == 2) req_x[1] = 8'h00;
         tick();
         expect_out(1, $sformatf("sole_idle%0d", r), 8'h00, 3'd0, 1'b0, 1'b0);
         tick();
      end
      expect_out(1, "sole_end", 8'h00, 3'd0, 1'b0, 1'b0);

      // unlimited hold
      req_x[2] = 8'b0000_0011;
      tick();
      for (int c = 0; c < 40; c++) begin
         expect_out(2, $sformatf("nolim%0d", c), 8'b0000_0001, 3'd0, 1'b1, 1'b0);
         tick();
      end
      req_x[2] = 8'b0000_0010;
      tick();
      expect_out(2, "nolim_gap", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      expect_out(2, "nolim_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      tick();
      expect_out(2, "nolim_own1", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
      req_x[2] = 8'h00;
      tick();
      tick();

      // reset while owner 5 holds
      req_x[0] = 8'b0010_0000;
      tick();
      expect_out(0, "mid_own5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
      tick();
      expect_out(0, "mid_own5b", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      expect_out(0, "mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      req_x[0] = 8'hFF;
      tick();
      expect_out(0, "mid_after", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
      req_x[0] = 8'h00;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
